data_sram_rsp: RTL

Responder end of the data SRAM port driven by the execute stage. It accepts one request per cycle on data_sram_en, data_sram_wen, data_sram_addr and data_sram_wdata, and returns registered read data to the memory stage one cycle later. Internally it holds a word-organised data RAM behind a one-entry write buffer with per-byte read forwarding, plus a small configuration region containing a free-running cycle counter and a scratch register.

---
 rtl/data_sram_rsp.sv | 118 +++++++++++
 1 files changed

// File: rtl/data_sram_rsp.sv
// data_sram_rsp: responder for the execute-stage data SRAM port.
// Word-organised RAM behind a one-entry write buffer with per-byte read
// forwarding, plus a configuration region (cycle counter, scratch register).
// Read data is registered and returned one cycle after the request.
module data_sram_rsp #(
    parameter int unsigned ADDR_W  = 12,
    parameter logic [15:0] CONF_HI = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata
);

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_idx;
    logic [3:0]        wb_be;
    logic [31:0]       wb_data;

    logic [31:0]       counter;
    logic [31:0]       scratch;

    logic              is_conf;
    logic              is_rd;
    logic              is_wr;
    logic [ADDR_W-1:0] req_idx;
    logic [31:0]       ram_word;
    logic [31:0]       merged;
    logic [31:0]       conf_word;
    logic              fwd_hit;
    logic              unused_addr_bits;

    // High address bits alias onto the RAM; the byte offset never selects a word.
    assign unused_addr_bits = ^{data_sram_addr[15:ADDR_W+2], data_sram_addr[1:0]};

    assign is_conf  = (data_sram_addr[31:16] == CONF_HI);
    assign is_rd    = data_sram_en && (data_sram_wen == 4'b0000);
    assign is_wr    = data_sram_en && (data_sram_wen != 4'b0000);
    assign req_idx  = data_sram_addr[ADDR_W+1:2];
    assign ram_word = mem[req_idx];
    assign fwd_hit  = wb_valid && (wb_idx == req_idx);

    // Merge pending buffered bytes over the array word, and decode config reads.
    always_comb begin
        merged    = ram_word;
        conf_word = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (fwd_hit && wb_be[i]) begin
                merged[8*i +: 8] = wb_data[8*i +: 8];
            end
        end
        case (data_sram_addr[3:2])
            2'b00:   conf_word = counter;
            2'b01:   conf_word = scratch;
            default: conf_word = '0;
        endcase
    end

    // Commit the buffered write into the array; a commit due at a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset && wb_valid) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wb_be[i]) begin
                    mem[wb_idx][8*i +: 8] <= wb_data[8*i +: 8];
                end
            end
        end
    end

    // Capture RAM writes into the one-entry buffer; it empties after one commit cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_idx   <= '0;
            wb_be    <= '0;
            wb_data  <= '0;
        end else if (is_wr && !is_conf) begin
            wb_valid <= 1'b1;
            wb_idx   <= req_idx;
            wb_be    <= data_sram_wen;
            wb_data  <= data_sram_wdata;
        end else begin
            wb_valid <= 1'b0;
        end
    end

    // Free-running cycle counter and directly-written scratch register.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            scratch <= '0;
        end else begin
            counter <= counter + 32'd1;
            if (is_wr && is_conf && (data_sram_addr[3:2] == 2'b01)) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (data_sram_wen[i]) begin
                        scratch[8*i +: 8] <= data_sram_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Register read data on read requests only; otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sram_rdata <= '0;
        end else if (is_rd) begin
            data_sram_rdata <= is_conf ? conf_word : merged;
        end
    end

endmodule
